// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer feeding the datapath control word.
// Owns PC and IR, handshakes instruction fetch and data-memory access, resolves Z/N branches.
module control_sequencer #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [15:0] IADDR,
  output logic        IREQ,
  input  logic [15:0] IDATA,
  input  logic        IVALID,
  output logic        MR,
  output logic        MW,
  input  logic        MRDY,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic [15:0] CTRWRD,
  output logic [15:0] Cin,
  output logic        HALTED
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_BRANCH = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ADI  = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_BRZ  = 4'hD;
  localparam logic [3:0] OP_BRN  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] FS_PASS_A = 4'b0000;
  localparam logic [3:0] FS_ADD    = 4'b0010;
  localparam logic [3:0] FS_SUB    = 4'b0101;
  localparam logic [3:0] FS_AND    = 4'b1000;
  localparam logic [3:0] FS_OR     = 4'b1001;
  localparam logic [3:0] FS_XOR    = 4'b1010;
  localparam logic [3:0] FS_NOT    = 4'b1011;
  localparam logic [3:0] FS_SHR    = 4'b1101;
  localparam logic [3:0] FS_SHL    = 4'b1110;

  // Datapath function select for the register-writing ALU opcodes.
  function automatic logic [3:0] fs_for_op(input logic [3:0] op);
    logic [3:0] fs;
    case (op)
      OP_MOV:  fs = FS_PASS_A;
      OP_ADD:  fs = FS_ADD;
      OP_SUB:  fs = FS_SUB;
      OP_AND:  fs = FS_AND;
      OP_OR:   fs = FS_OR;
      OP_XOR:  fs = FS_XOR;
      OP_NOT:  fs = FS_NOT;
      OP_SHL:  fs = FS_SHL;
      OP_SHR:  fs = FS_SHR;
      OP_ADI:  fs = FS_ADD;
      default: fs = FS_PASS_A;
    endcase
    return fs;
  endfunction

  state_t      state_r, state_nx;
  logic [15:0] pc_r, pc_nx;
  logic [15:0] ir_r, ir_nx;
  logic        z_r, z_nx;
  logic        n_r, n_nx;

  logic [3:0]  op_s;
  logic [2:0]  dr_s, sa_s, sb_s;
  logic [15:0] imm_s, off_s;
  logic        take_s;

  logic [2:0]  da_s, aa_s, ba_s;
  logic [3:0]  fs_s;
  logic        mb_s, md_s, rw_s;
  logic        ireq_s, mr_s, mw_s, halted_s;
  logic        unused_s;

  assign op_s  = ir_r[15:12];
  assign dr_s  = ir_r[11:9];
  assign sa_s  = ir_r[8:6];
  assign sb_s  = ir_r[5:3];
  assign imm_s = {13'd0, sb_s};
  assign off_s = {{10{ir_r[11]}}, ir_r[11:9], ir_r[5:3]};
  assign take_s = (op_s == OP_BRN) ? n_r : z_r;

  // V and C are reserved status inputs; IR[2:0] carries no information.
  assign unused_s = ^{V, C, ir_r[2:0]};

  // Sequencer state, program counter, instruction register and branch flag latches.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= S_INIT;
      pc_r    <= PC_RESET;
      ir_r    <= 16'h0000;
      z_r     <= 1'b0;
      n_r     <= 1'b0;
    end else begin
      state_r <= state_nx;
      pc_r    <= pc_nx;
      ir_r    <= ir_nx;
      z_r     <= z_nx;
      n_r     <= n_nx;
    end
  end

  // Next-state logic and per-state control word decode.
  always_comb begin
    state_nx = state_r;
    pc_nx    = pc_r;
    ir_nx    = ir_r;
    z_nx     = z_r;
    n_nx     = n_r;
    da_s     = 3'd0;
    aa_s     = 3'd0;
    ba_s     = 3'd0;
    mb_s     = 1'b0;
    fs_s     = FS_PASS_A;
    md_s     = 1'b0;
    rw_s     = 1'b0;
    ireq_s   = 1'b0;
    mr_s     = 1'b0;
    mw_s     = 1'b0;
    halted_s = 1'b0;
    case (state_r)
      S_INIT: begin
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        ireq_s = 1'b1;
        if (IVALID) begin
          ir_nx    = IDATA;
          pc_nx    = pc_r + 16'd1;
          state_nx = S_EXEC;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_EXEC: begin
        case (op_s)
          OP_NOP: begin
            state_nx = S_FETCH;
          end
          OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_NOT, OP_SHL, OP_SHR, OP_ADI: begin
            da_s     = dr_s;
            aa_s     = sa_s;
            ba_s     = sb_s;
            mb_s     = (op_s == OP_ADI);
            fs_s     = fs_for_op(op_s);
            rw_s     = 1'b1;
            state_nx = S_FETCH;
          end
          OP_LD: begin
            // Write-back happens only in the cycle memory delivers data on Din.
            da_s = dr_s;
            aa_s = sa_s;
            md_s = 1'b1;
            mr_s = 1'b1;
            rw_s = MRDY;
            if (MRDY) begin
              state_nx = S_FETCH;
            end else begin
              state_nx = S_EXEC;
            end
          end
          OP_ST: begin
            aa_s = sa_s;
            ba_s = sb_s;
            mw_s = 1'b1;
            if (MRDY) begin
              state_nx = S_FETCH;
            end else begin
              state_nx = S_EXEC;
            end
          end
          OP_BRZ, OP_BRN: begin
            aa_s     = sa_s;
            fs_s     = FS_PASS_A;
            z_nx     = Z;
            n_nx     = N;
            state_nx = S_BRANCH;
          end
          OP_HALT: begin
            state_nx = S_HALT;
          end
          default: begin
            state_nx = S_FETCH;
          end
        endcase
      end
      S_BRANCH: begin
        // PC already points past the branch, so the offset is relative to the next instruction.
        if (take_s) begin
          pc_nx = pc_r + off_s;
        end else begin
          pc_nx = pc_r;
        end
        state_nx = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_INIT;
      end
    endcase
  end

  assign IADDR  = pc_r;
  assign IREQ   = ireq_s;
  assign MR     = mr_s;
  assign MW     = mw_s;
  assign HALTED = halted_s;
  assign CTRWRD = {da_s, aa_s, ba_s, mb_s, fs_s, md_s, rw_s};
  assign Cin    = mb_s ? imm_s : 16'h0000;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table-driven ALU vectors through a scoreboard queue,
// plus hand-written load/store/branch/halt/reset sequences.
module tb_control_sequencer;

  localparam logic [15:0] PCR = 16'h0010;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] IADDR;
  logic        IREQ;
  logic [15:0] IDATA = 16'h0000;
  logic        IVALID = 1'b0;
  logic        MR, MW;
  logic        MRDY = 1'b0;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
  logic [15:0] CTRWRD, Cin;
  logic        HALTED;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_pc;

  typedef struct {
    logic [15:0] instr;
    int          waits;
    logic [15:0] cw;
    logic [15:0] cin;
  } vec_t;

  typedef struct {
    logic [15:0] cw;
    logic [15:0] cin;
    logic [15:0] pc;
  } exp_t;

  vec_t vecs [12];
  exp_t sb_q [$];

  control_sequencer #(.PC_RESET(PCR)) dut (
    .CLK(CLK), .RESET(RESET), .IADDR(IADDR), .IREQ(IREQ), .IDATA(IDATA),
    .IVALID(IVALID), .MR(MR), .MW(MW), .MRDY(MRDY), .V(V), .C(C), .N(N), .Z(Z),
    .CTRWRD(CTRWRD), .Cin(Cin), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Waits (bounded) for a fetch request, holds IVALID low for 'waits' cycles, then delivers instr.
  // Returns at the falling edge of the EXEC cycle.
  task automatic fetch(input logic [15:0] instr, input int waits);
    int guard = 0;
    while (IREQ !== 1'b1 && guard < 16) begin
      @(negedge CLK);
      guard++;
    end
    chk1("fetch_ireq", IREQ, 1'b1);
    chk16("fetch_iaddr", IADDR, exp_pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      chk1("fetch_wait_ireq", IREQ, 1'b1);
      chk16("fetch_wait_cw", CTRWRD, 16'h0000);
    end
    IDATA  = instr;
    IVALID = 1'b1;
    @(negedge CLK);
    IVALID = 1'b0;
    IDATA  = 16'h0000;
    exp_pc = exp_pc + 16'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   guard;

    vecs[0]  = '{16'h2298, 2, 16'h2989, 16'h0000};
    vecs[1]  = '{16'hA2A8, 0, 16'h2AC9, 16'h0005};
    vecs[2]  = '{16'h3AD0, 1, 16'hAD15, 16'h0000};
    vecs[3]  = '{16'h1E40, 0, 16'hE401, 16'h0000};
    vecs[4]  = '{16'h7248, 0, 16'h24AD, 16'h0000};
    vecs[5]  = '{16'h8418, 3, 16'h41B9, 16'h0000};
    vecs[6]  = '{16'h9638, 0, 16'h63B5, 16'h0000};
    vecs[7]  = '{16'h6FF8, 0, 16'hFFA9, 16'h0000};
    vecs[8]  = '{16'h4000, 1, 16'h0021, 16'h0000};
    vecs[9]  = '{16'h5C00, 0, 16'hC025, 16'h0000};
    vecs[10] = '{16'h0FF8, 0, 16'h0000, 16'h0000};
    vecs[11] = '{16'hA038, 0, 16'h03C9, 16'h0007};

    // Reset and INIT cycle.
    @(negedge CLK);
    chk16("rst_cw", CTRWRD, 16'h0000);
    chk1("rst_ireq", IREQ, 1'b0);
    chk16("rst_iaddr", IADDR, PCR);
    chk1("rst_mr", MR, 1'b0);
    chk1("rst_halted", HALTED, 1'b0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    exp_pc = PCR;
    @(negedge CLK);
    chk16("init_cw", CTRWRD, 16'h0000);
    chk1("init_ireq", IREQ, 1'b0);
    chk16("init_iaddr", IADDR, PCR);
    @(negedge CLK);
    chk1("first_fetch_ireq", IREQ, 1'b1);

    // Single-cycle EXEC instructions through the scoreboard.
    for (int k = 0; k < 12; k++) begin
      e.cw  = vecs[k].cw;
      e.cin = vecs[k].cin;
      e.pc  = exp_pc + 16'd1;
      sb_q.push_back(e);
      fetch(vecs[k].instr, vecs[k].waits);
      e = sb_q.pop_front();
      chk16("exec_cw", CTRWRD, e.cw);
      chk16("exec_cin", Cin, e.cin);
      chk16("exec_pc", IADDR, e.pc);
      chk1("exec_mr", MR, 1'b0);
      chk1("exec_ireq", IREQ, 1'b0);
      @(negedge CLK);
      chk16("post_exec_cw", CTRWRD, 16'h0000);
      chk1("post_exec_ireq", IREQ, 1'b1);
    end

    // Load with three memory wait cycles.
    fetch(16'hB280, 0);
    MRDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk1("ld_mr_wait", MR, 1'b1);
      chk16("ld_cw_wait", CTRWRD, 16'h2802);
      @(negedge CLK);
    end
    chk1("ld_mr_last", MR, 1'b1);
    MRDY = 1'b1;
    #1;
    chk16("ld_cw_ready", CTRWRD, 16'h2803);
    @(negedge CLK);
    MRDY = 1'b0;
    chk1("ld_mr_drop", MR, 1'b0);
    chk1("ld_back_fetch", IREQ, 1'b1);

    // Store completing immediately.
    fetch(16'hC298, 0);
    MRDY = 1'b1;
    #1;
    chk1("st_mw", MW, 1'b1);
    chk1("st_mr", MR, 1'b0);
    chk16("st_cw", CTRWRD, 16'h0980);
    @(negedge CLK);
    MRDY = 1'b0;
    chk1("st_mw_drop", MW, 1'b0);

    // Pad with NOPs up to PC 0x20.
    guard = 0;
    while (exp_pc != 16'h0020 && guard < 8) begin
      fetch(16'h0000, 0);
      guard++;
    end
    chk16("pad_pc", exp_pc, 16'h0020);

    // BRZ R0, -1 taken: Z changes after the EXEC cycle and must not matter.
    fetch(16'hDE38, 0);
    Z = 1'b1;
    chk16("brz_exec_cw", CTRWRD, 16'h0000);
    @(negedge CLK);
    Z = 1'b0;
    chk16("brz_branch_cw", CTRWRD, 16'h0000);
    chk1("brz_branch_ireq", IREQ, 1'b0);
    @(negedge CLK);
    exp_pc = exp_pc + 16'hFFFF;
    chk16("brz_taken_iaddr", IADDR, 16'h0020);

    // Same BRZ not taken.
    fetch(16'hDE38, 0);
    Z = 1'b0;
    @(negedge CLK);
    Z = 1'b1;
    @(negedge CLK);
    chk16("brz_nt_iaddr", IADDR, 16'h0021);

    // BRN R3, +2 taken on N.
    fetch(16'hE0D0, 0);
    N = 1'b1;
    Z = 1'b0;
    chk16("brn_exec_cw", CTRWRD, 16'h0C00);
    @(negedge CLK);
    N = 1'b0;
    @(negedge CLK);
    exp_pc = exp_pc + 16'd2;
    chk16("brn_taken_iaddr", IADDR, 16'h0024);

    // BRN not taken: Z set, N clear.
    fetch(16'hE0D0, 0);
    N = 1'b0;
    Z = 1'b1;
    @(negedge CLK);
    Z = 1'b0;
    @(negedge CLK);
    chk16("brn_nt_iaddr", IADDR, 16'h0025);

    // HALT ignores further instruction-valid.
    fetch(16'hF000, 0);
    chk16("halt_exec_cw", CTRWRD, 16'h0000);
    IVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk1("halted", HALTED, 1'b1);
      chk1("halt_ireq", IREQ, 1'b0);
      chk16("halt_cw", CTRWRD, 16'h0000);
      chk16("halt_iaddr", IADDR, exp_pc);
    end
    IVALID = 1'b0;

    // Reset out of HALT, then reset in the middle of a load wait.
    RESET = 1'b1;
    #1;
    chk1("halt_rst_halted", HALTED, 1'b0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    exp_pc = PCR;
    fetch(16'hB280, 0);
    MRDY = 1'b0;
    chk1("ldr_mr", MR, 1'b1);
    @(negedge CLK);
    chk1("ldr_mr_wait", MR, 1'b1);
    RESET = 1'b1;
    #1;
    chk1("ldr_mr_drop", MR, 1'b0);
    chk1("ldr_ireq", IREQ, 1'b0);
    chk16("ldr_cw", CTRWRD, 16'h0000);
    chk16("ldr_iaddr", IADDR, PCR);
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk1("ldr_init_ireq", IREQ, 1'b0);
    @(negedge CLK);
    chk1("ldr_fetch_ireq", IREQ, 1'b1);
    chk16("ldr_fetch_iaddr", IADDR, PCR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
